mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that shares the CPU's single memory bus (mem_read/mem_write/mem_ack handshake) between the instruction-fetch unit and the load/store unit. Grants one requester per bus transaction with round-robin fairness and drives the registered bus strobes. A watchdog aborts transactions whose mem_ack never arrives. It sits inside cpu between the pipeline front/back ends and the external memory port. It exports a 32-bit status word for the seven-segment debug display.

## Interface
- TIMEOUT_CYCLES, 255: cycles in BUSY without mem_ack before abort; 0 disables watchdog.
- TIMEOUT_W, 8: width of watchdog counter; TIMEOUT_CYCLES < 2^TIMEOUT_W.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, held until if_ack/if_err.
- if_addr  in  32  fetch address, stable while if_req.
- if_ack / if_err  out  1 each  one-cycle completion / abort pulse to fetch.
- if_rdata  out  32  read data, valid when if_ack.
- d_req, d_we  in  1 each  data request, 1 = write.
- d_addr, d_wdata  in  32 each  data address / write data, stable while d_req.
- d_ack / d_err  out  1 each  completion / abort pulse to data port.
- d_rdata  out  32  read data, valid when d_ack (0 after write).
- mem_read, mem_write  out  1 each  bus strobes, registered.
- mem_addr, mem_write_data  out  32 each  registered bus attributes.
- mem_ack  in  1  bus completion.
- mem_read_data  in  32  bus read data, valid with mem_ack.
- dbg_status  out  32  [31:16] completed count, [15:8] timeout count, [3] last_grant, [1:0] state.

## Operation
- States: IDLE=0, BUSY=1, RESP=2.
- IDLE, no req: all strobes 0.
- IDLE, single req: grant it.
- IDLE, both req: grant the port not in last_grant. last_grant resets to data, so fetch wins first contention.
- IDLE, on grant: register owner, addr, we (fetch: we=0), wdata (fetch: 0), last_grant=owner. Enter BUSY. Clear watchdog.
- BUSY: mem_read = !we, mem_write = we. Watchdog increments each cycle.
- BUSY, mem_ack=1: latch mem_read_data (0 if write). Drop strobes. Completed count += 1 (wraps at 16 bits). Enter RESP with ack flag.
- BUSY, watchdog == TIMEOUT_CYCLES−1 and mem_ack=0: drop strobes. Rdata = 0. Timeout count += 1 (saturates at 255). Enter RESP with err flag.
- BUSY, mem_ack and timeout in the same cycle: ack wins.
- RESP: owner's ack or err = 1 for exactly this cycle; the other port's ack/err stay 0. Rdata is presented on the owner's rdata only. Next state is IDLE.
- mem_ack in IDLE/RESP is ignored. No counter change.
- Requester keeping req high after its ack is a new request in IDLE.
- Reset (any state, including mid-BUSY): immediately all outputs 0, state IDLE, counters 0, last_grant=data. In-flight transaction is dropped with no ack/err.

## Timing
- Reset value of every output: 0.
- Request seen in IDLE at edge n → strobes high from cycle n+1.
- mem_ack sampled at edge k → strobes low and ack high in cycle k+1 → IDLE at k+2.
- Minimum 3 cycles per transaction (ack in first BUSY cycle). Back-to-back throughput 1 transaction / 3 cycles.
- Timeout: strobes high exactly TIMEOUT_CYCLES cycles, err in following cycle.
- Bus attributes are constant while strobes are high.

## Structure
- Shared header mem_arb_defs.vh: state encodings, OWNER_IF=0 / OWNER_D=1, dbg_status field offsets.
- Sub-module mem_watchdog: counter with clear/enable/expire, parameterised by TIMEOUT_CYCLES/TIMEOUT_W.
- Everything else stays in mem_arbiter.

## Test plan
- Fetch read 0x100, mem_ack in 2nd BUSY cycle with data 0xDEADBEEF → mem_read high 2 cycles, mem_addr 0x100; if_ack 1 cycle; if_rdata 0xDEADBEEF; completed=1.
- Data write 0x200←0x12345678 → mem_write=1, mem_write_data 0x12345678; d_ack; d_rdata 0.
- Both req held continuously, ack each first BUSY cycle → grants alternate IF, D, IF, D, one per 3 cycles.
- TIMEOUT_CYCLES=4, no mem_ack → strobes high 4 cycles; d_err pulse; timeout count=1; then mem_ack alone ignored.
- mem_ack on the same cycle as expiry → ack pulse, no err, timeout count unchanged.
- reset low mid-BUSY → strobes 0 asynchronously; no ack/err; dbg_status 0 after release.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg
//   Shared definitions for the two-port memory arbiter: FSM state encoding,
//   bus-owner encoding, dbg_status field offsets and a status packing helper.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arb_state_e;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_D  = 1'b1;

    localparam int DBG_DONE_LSB  = 16;
    localparam int DBG_TOUT_LSB  = 8;
    localparam int DBG_LAST_BIT  = 3;
    localparam int DBG_STATE_LSB = 0;

    function automatic logic [31:0] pack_status(input logic [15:0] done,
                                                input logic [7:0]  tout,
                                                input logic        last,
                                                input arb_state_e  st);
        logic [31:0] s;
        s = '0;
        s[DBG_DONE_LSB +: 16] = done;
        s[DBG_TOUT_LSB +: 8]  = tout;
        s[DBG_LAST_BIT]       = last;
        s[DBG_STATE_LSB +: 2] = st;
        return s;
    endfunction

endpackage

// File: rtl/mem_watchdog.sv
// mem_watchdog
//   Cycle counter that flags a bus transaction which has been outstanding for
//   TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES = 0 disables the expire output.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-low reset
//   clr    - force count to zero (held outside the BUSY phase)
//   en     - count this cycle
//   expire - high during the last permitted cycle (count == TIMEOUT_CYCLES-1)
module mem_watchdog #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam logic [TIMEOUT_W-1:0] LAST_CNT =
        (TIMEOUT_CYCLES == 0) ? '0 : TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            // saturate rather than wrap so a disabled watchdog never aliases
            cnt_d = cnt_q + TIMEOUT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (TIMEOUT_CYCLES != 0) && en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one memory bus between the instruction-fetch port (if_*) and the
//   load/store port (d_*). One transaction at a time, round-robin on
//   contention, registered bus strobes/attributes, watchdog abort.
// Ports:
//   clk, reset               - clock, asynchronous active-low reset
//   if_req/if_addr           - fetch request (read only)
//   if_ack/if_err/if_rdata   - fetch completion/abort pulse, read data
//   d_req/d_we/d_addr/d_wdata- data request
//   d_ack/d_err/d_rdata      - data completion/abort pulse, read data
//   mem_read/mem_write       - registered bus strobes
//   mem_addr/mem_write_data  - registered bus attributes
//   mem_ack/mem_read_data    - bus completion and read data
//   dbg_status               - {completed[15:0], timeouts[7:0], 4'b0,
//                               last_grant, 1'b0, state[1:0]}
//
// state | meaning
// IDLE  | no transaction; arbitrate and grant on any request
// BUSY  | strobes asserted, waiting for mem_ack or watchdog expiry
// RESP  | one-cycle ack/err pulse to the owner, then back to IDLE
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic        if_err,
    output logic [31:0] if_rdata,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    output logic        d_ack,
    output logic        d_err,
    output logic [31:0] d_rdata,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic        mem_ack,
    input  logic [31:0] mem_read_data,
    output logic [31:0] dbg_status
);

    arb_state_e  state_q, state_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        last_grant_q, last_grant_d;
    logic        granted_q, granted_d;
    logic [15:0] done_q, done_d;
    logic [7:0]  tout_q, tout_d;
    logic        mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;
    logic        if_ack_q, if_ack_d;
    logic        if_err_q, if_err_d;
    logic        d_ack_q, d_ack_d;
    logic        d_err_q, d_err_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic        eff_last;
    logic        gnt;
    logic        grant_we;
    logic [31:0] rsp_data;
    logic        wd_expire;

    mem_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_W      (TIMEOUT_W)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clr    (state_q != ST_BUSY),
        .en     (state_q == ST_BUSY),
        .expire (wd_expire)
    );

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        last_grant_d = last_grant_q;
        granted_d    = granted_q;
        done_d       = done_q;
        tout_d       = tout_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        if_ack_d     = 1'b0;
        if_err_d     = 1'b0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        if_rdata_d   = '0;
        d_rdata_d    = '0;

        // last_grant_q reads as 0 on the debug display out of reset, but the
        // arbiter treats "no grant yet" as data-last so fetch wins first.
        eff_last = granted_q ? last_grant_q : OWNER_D;
        if (if_req && d_req) begin
            gnt = (eff_last == OWNER_IF) ? OWNER_D : OWNER_IF;
        end else begin
            gnt = d_req ? OWNER_D : OWNER_IF;
        end
        grant_we = (gnt == OWNER_D) && d_we;
        rsp_data = we_q ? '0 : mem_read_data;

        case (state_q)
            ST_IDLE: begin
                if (if_req || d_req) begin
                    owner_d      = gnt;
                    addr_d       = (gnt == OWNER_D) ? d_addr : if_addr;
                    we_d         = grant_we;
                    wdata_d      = (gnt == OWNER_D) ? d_wdata : '0;
                    last_grant_d = gnt;
                    granted_d    = 1'b1;
                    mem_read_d   = !grant_we;
                    mem_write_d  = grant_we;
                    state_d      = ST_BUSY;
                end
            end
            ST_BUSY: begin
                // ack takes priority over a same-cycle watchdog expiry
                if (mem_ack) begin
                    done_d  = done_q + 16'd1;
                    state_d = ST_RESP;
                    if (owner_q == OWNER_D) begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = rsp_data;
                    end else begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = rsp_data;
                    end
                end else if (wd_expire) begin
                    tout_d  = (tout_q == 8'hFF) ? tout_q : tout_q + 8'd1;
                    state_d = ST_RESP;
                    if (owner_q == OWNER_D) begin
                        d_err_d = 1'b1;
                    end else begin
                        if_err_d = 1'b1;
                    end
                end else begin
                    mem_read_d  = mem_read_q;
                    mem_write_d = mem_write_q;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWNER_IF;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            last_grant_q <= 1'b0;
            granted_q    <= 1'b0;
            done_q       <= '0;
            tout_q       <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            if_ack_q     <= 1'b0;
            if_err_q     <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            last_grant_q <= last_grant_d;
            granted_q    <= granted_d;
            done_q       <= done_d;
            tout_q       <= tout_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            if_ack_q     <= if_ack_d;
            if_err_q     <= if_err_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign if_ack         = if_ack_q;
    assign if_err         = if_err_q;
    assign if_rdata       = if_rdata_q;
    assign d_ack          = d_ack_q;
    assign d_err          = d_err_q;
    assign d_rdata        = d_rdata_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_addr       = addr_q;
    assign mem_write_data = wdata_q;
    assign dbg_status     = pack_status(done_q, tout_q, last_grant_q, state_q);

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Randomised and directed stimulus for mem_arbiter, checked every cycle
//   against a transaction-level reference model, plus literal expectations
//   for the directed scenarios.
module tb_mem_arbiter;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack, if_err;
    logic [31:0] if_rdata;
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [31:0] d_addr = '0, d_wdata = '0;
    logic        d_ack, d_err;
    logic [31:0] d_rdata;
    logic        mem_read, mem_write;
    logic [31:0] mem_addr, mem_write_data;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_read_data = '0;
    logic [31:0] dbg_status;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_ack         (if_ack),
        .if_err         (if_err),
        .if_rdata       (if_rdata),
        .d_req          (d_req),
        .d_we           (d_we),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .d_ack          (d_ack),
        .d_err          (d_err),
        .d_rdata        (d_rdata),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_addr       (mem_addr),
        .mem_write_data (mem_write_data),
        .mem_ack        (mem_ack),
        .mem_read_data  (mem_read_data),
        .dbg_status     (dbg_status)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    // One outstanding transaction record; m_busy = on the bus, m_resp = the
    // cycle its outcome is reported. m_last = -1 until the first grant.
    bit          m_busy = 0, m_resp = 0, m_ok = 0, m_owner = 0, m_we = 0;
    logic [31:0] m_addr = '0, m_wdata = '0, m_data = '0;
    int          m_age = 0, m_done = 0, m_tout = 0, m_last = -1;
    bit          chk_en = 1;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_busy = 0; m_resp = 0; m_ok = 0; m_data = '0;
            m_done = 0; m_tout = 0; m_last = -1; m_age = 0;
        end else if (m_resp) begin
            m_resp = 0;
        end else if (m_busy) begin
            if (mem_ack) begin
                m_ok   = 1;
                m_data = m_we ? 32'h0 : mem_read_data;
                m_done = (m_done + 1) % 65536;
                m_busy = 0;
                m_resp = 1;
            end else if (TO != 0 && m_age == TO - 1) begin
                m_ok   = 0;
                m_data = '0;
                m_tout = (m_tout < 255) ? m_tout + 1 : 255;
                m_busy = 0;
                m_resp = 1;
            end else begin
                m_age++;
            end
        end else if (if_req || d_req) begin
            if (if_req && d_req) m_owner = (m_last == 0);
            else                 m_owner = d_req;
            m_addr  = m_owner ? d_addr : if_addr;
            m_we    = m_owner && d_we;
            m_wdata = d_wdata;
            m_last  = int'(m_owner);
            m_busy  = 1;
            m_age   = 0;
        end
    end

    always @(negedge clk) begin
        logic [31:0] exp_dbg;
        if (chk_en) begin
            exp_dbg = 32'((m_done << 16) | (m_tout << 8) | ((m_last == 1) ? 8 : 0)
                          | (m_busy ? 1 : (m_resp ? 2 : 0)));
            chk("mem_read",  {31'b0, mem_read},  {31'b0, m_busy && !m_we});
            chk("mem_write", {31'b0, mem_write}, {31'b0, m_busy && m_we});
            if (m_busy) chk("mem_addr", mem_addr, m_addr);
            if (m_busy && m_we) chk("mem_write_data", mem_write_data, m_wdata);
            chk("if_ack", {31'b0, if_ack}, {31'b0, m_resp && m_ok && !m_owner});
            chk("if_err", {31'b0, if_err}, {31'b0, m_resp && !m_ok && !m_owner});
            chk("d_ack",  {31'b0, d_ack},  {31'b0, m_resp && m_ok && m_owner});
            chk("d_err",  {31'b0, d_err},  {31'b0, m_resp && !m_ok && m_owner});
            chk("if_rdata", if_rdata, (m_resp && m_ok && !m_owner) ? m_data : 32'h0);
            chk("d_rdata",  d_rdata,  (m_resp && m_ok && m_owner) ? m_data : 32'h0);
            chk("dbg_status", dbg_status, exp_dbg);
        end
    end

    // ---------------- directed helpers ----------------
    // Issue one request and answer it lat strobe cycles in (0 = never).
    // Called just after a negedge; returns at the negedge of the response.
    task automatic do_txn(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wd, input int lat, input logic [31:0] rd,
                          output int strobes, output bit ok, output bit err,
                          output logic [31:0] rdv);
        bit done;
        strobes = 0; ok = 0; err = 0; rdv = '0; done = 0;
        if (port) begin d_req = 1; d_we = we; d_addr = addr; d_wdata = wd; end
        else      begin if_req = 1; if_addr = addr; end
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (port ? (d_ack || d_err) : (if_ack || if_err)) begin
                ok   = port ? d_ack : if_ack;
                err  = port ? d_err : if_err;
                rdv  = port ? d_rdata : if_rdata;
                done = 1;
                if (port) d_req = 0; else if_req = 0;
                mem_ack = 0;
            end else if (mem_read || mem_write) begin
                strobes++;
                chk("txn_addr", mem_addr, addr);
                chk("txn_we", {31'b0, mem_write}, {31'b0, we});
                if (we) chk("txn_wdata", mem_write_data, wd);
                mem_ack       = (strobes == lat);
                mem_read_data = rd;
            end else begin
                mem_ack = 0;
            end
        end
        if (!done) chk("txn_timeout", 32'd0, 32'd1);
    endtask

    // Let both ports finish their outstanding requests with immediate acks.
    task automatic drain();
        bit idle;
        idle = 0;
        for (int i = 0; i < 40 && !idle; i++) begin
            @(negedge clk);
            mem_ack = mem_read || mem_write;
            mem_read_data = $urandom;
            if (if_ack || if_err) if_req = 0;
            if (d_ack || d_err) d_req = 0;
            idle = !if_req && !d_req;
        end
        if (!idle) chk("drain_timeout", 32'd0, 32'd1);
        mem_ack = 0;
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int st; bit ok, err; logic [31:0] rdv;
        int g_own[$]; int g_cyc[$];

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_mem_read", {31'b0, mem_read}, 32'd0);
        chk("rst_if_ack", {31'b0, if_ack}, 32'd0);
        chk("rst_dbg", dbg_status, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        reset = 1;
        @(negedge clk);

        // fetch read, ack in 2nd BUSY cycle
        do_txn(0, 0, 32'h100, 32'h0, 2, 32'hDEADBEEF, st, ok, err, rdv);
        chk("t1_strobes", st, 2);
        chk("t1_ok", {31'b0, ok}, 32'd1);
        chk("t1_err", {31'b0, err}, 32'd0);
        chk("t1_rdata", rdv, 32'hDEADBEEF);
        @(negedge clk);
        chk("t1_ack_gone", {31'b0, if_ack}, 32'd0);
        chk("t1_done", {16'b0, dbg_status[31:16]}, 32'd1);

        // data write
        do_txn(1, 1, 32'h200, 32'h12345678, 1, 32'hCAFEF00D, st, ok, err, rdv);
        chk("t2_strobes", st, 1);
        chk("t2_ok", {31'b0, ok}, 32'd1);
        chk("t2_rdata_zero", rdv, 32'h0);
        @(negedge clk);
        chk("t2_done", {16'b0, dbg_status[31:16]}, 32'd2);
        chk("t2_last_d", {31'b0, dbg_status[3]}, 32'd1);

        // timeout on the data port, then a stray mem_ack
        do_txn(1, 0, 32'h300, 32'h0, 0, 32'h0, st, ok, err, rdv);
        chk("t3_strobes", st, TO);
        chk("t3_err", {31'b0, err}, 32'd1);
        chk("t3_ok", {31'b0, ok}, 32'd0);
        @(negedge clk);
        chk("t3_tout", {24'b0, dbg_status[15:8]}, 32'd1);
        mem_ack = 1;
        repeat (2) @(negedge clk);
        mem_ack = 0;
        chk("t3_stray_done", {16'b0, dbg_status[31:16]}, 32'd2);
        chk("t3_stray_tout", {24'b0, dbg_status[15:8]}, 32'd1);
        chk("t3_stray_state", {30'b0, dbg_status[1:0]}, 32'd0);

        // ack coincides with watchdog expiry
        do_txn(0, 0, 32'h400, 32'h0, TO, 32'h55AA55AA, st, ok, err, rdv);
        chk("t4_strobes", st, TO);
        chk("t4_ok", {31'b0, ok}, 32'd1);
        chk("t4_err", {31'b0, err}, 32'd0);
        chk("t4_rdata", rdv, 32'h55AA55AA);
        @(negedge clk);
        chk("t4_tout", {24'b0, dbg_status[15:8]}, 32'd1);
        chk("t4_done", {16'b0, dbg_status[31:16]}, 32'd3);

        // reset mid-BUSY
        if_req = 1; if_addr = 32'h500;
        st = 0;
        for (int i = 0; i < 5 && st == 0; i++) begin
            @(negedge clk);
            if (mem_read) st = 1;
        end
        chk("t5_reached_busy", st, 1);
        #2 reset = 0;
        #1;
        chk("t5_async_read", {31'b0, mem_read}, 32'd0);
        chk("t5_async_dbg", dbg_status, 32'd0);
        @(negedge clk);
        chk("t5_no_ack", {30'b0, if_ack, if_err}, 32'd0);
        if_req = 0;
        reset = 1;
        @(negedge clk);
        chk("t5_dbg_after", dbg_status, 32'd0);
        chk("t5_no_ack_after", {30'b0, if_ack, if_err}, 32'd0);

        // both requesting continuously: alternate IF, D, ... every 3 cycles
        if_req = 1; if_addr = 32'hA000;
        d_req = 1; d_we = 0; d_addr = 32'hB000;
        for (int i = 1; i <= 13; i++) begin
            @(negedge clk);
            if (mem_read || mem_write) begin
                g_own.push_back(mem_addr == 32'hB000 ? 1 : 0);
                g_cyc.push_back(i);
                mem_ack = 1;
            end else begin
                mem_ack = 0;
            end
        end
        chk("t6_ngrants", g_own.size(), 5);
        if (g_own.size() > 0) chk("t6_first_if", g_own[0], 0);
        for (int i = 1; i < g_own.size(); i++) begin
            chk("t6_alternate", g_own[i], 1 - g_own[i-1]);
            chk("t6_spacing", g_cyc[i] - g_cyc[i-1], 3);
        end
        drain();

        // randomised traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            if (if_req && (if_ack || if_err)) begin
                if_req = 1'($urandom_range(0, 1));
                if_addr = $urandom;
            end else if (!if_req && $urandom_range(0, 3) == 0) begin
                if_req = 1; if_addr = $urandom;
            end
            if (d_req && (d_ack || d_err)) begin
                d_req = 1'($urandom_range(0, 1));
                d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            end else if (!d_req && $urandom_range(0, 3) == 0) begin
                d_req = 1;
                d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
            end
            mem_ack = ($urandom_range(0, 2) == 0);
            mem_read_data = $urandom;
        end
        drain();

        // timeout counter saturation
        mem_ack = 0;
        if_req = 1; d_req = 1; d_we = 1;
        repeat (1700) @(negedge clk);
        chk("t8_tout_sat", {24'b0, dbg_status[15:8]}, 32'd255);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
